// File: rtl/real_to_pwl.sv
// Converts a stepwise signed sample stream into a slope-limited piecewise-linear waveform.
// Each change of in_val starts a 2^TR_LOG2-cycle linear ramp from the current output toward the new target.
module real_to_pwl #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned TR_LOG2 = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [WIDTH-1:0] in_val,
   output logic signed [WIDTH-1:0] out_val,
   output logic signed [WIDTH-1:0] out_slope,
   output logic                    busy,
   output logic                    seg_start
);

   localparam int unsigned DW     = WIDTH + 1;
   localparam int unsigned RW     = TR_LOG2 + 1;
   localparam bit          RAMPED = (TR_LOG2 != 0);
   localparam logic signed [DW-1:0] BIAS      = DW'((2 ** TR_LOG2) - 1);
   localparam logic        [RW-1:0] RAMP_LAST = RW'((2 ** TR_LOG2) - 1);

   logic signed [WIDTH-1:0] target, target_d;
   logic signed [WIDTH-1:0] slope, slope_d;
   logic        [RW-1:0]    remaining, remaining_d;
   logic signed [WIDTH-1:0] out_d;
   logic                    seg_d;

   logic signed [DW-1:0]    delta;
   logic signed [DW-1:0]    biased;
   logic signed [WIDTH-1:0] seg_slope;

   // Per-cycle step of a new segment, truncated toward zero so the ramp never overshoots.
   always_comb begin
      delta     = {in_val[WIDTH-1], in_val} - {out_val[WIDTH-1], out_val};
      biased    = delta[DW-1] ? (delta + BIAS) : delta;
      seg_slope = WIDTH'(biased >>> TR_LOG2);
   end

   always_comb begin
      target_d    = target;
      slope_d     = slope;
      remaining_d = remaining;
      out_d       = out_val;
      seg_d       = 1'b0;
      if (in_val != target) begin
         target_d = in_val;
         seg_d    = 1'b1;
         if (RAMPED) begin
            out_d       = out_val + seg_slope;
            slope_d     = seg_slope;
            remaining_d = RAMP_LAST;
         end else begin
            out_d       = in_val;
            slope_d     = '0;
            remaining_d = '0;
         end
      end else if (remaining > RW'(1)) begin
         out_d       = out_val + slope;
         remaining_d = remaining - RW'(1);
      end else if (remaining == RW'(1)) begin
         // Final step snaps to target, absorbing the truncation residue.
         out_d       = target;
         slope_d     = '0;
         remaining_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         target    <= '0;
         slope     <= '0;
         remaining <= '0;
         out_val   <= '0;
         seg_start <= 1'b0;
      end else begin
         target    <= target_d;
         slope     <= slope_d;
         remaining <= remaining_d;
         out_val   <= out_d;
         seg_start <= seg_d;
      end
   end

   assign out_slope = slope;
   assign busy      = (remaining != '0);

endmodule

// File: tb/tb_real_to_pwl.sv
// Self-checking bench for real_to_pwl: directed test-plan scenarios plus randomized
// stimulus against an arithmetic ramp model, for TR_LOG2 = 2 and TR_LOG2 = 0.
module tb_real_to_pwl;

   logic               clk = 1'b0;
   logic               rst;
   logic signed [15:0] in_val;
   logic signed [15:0] out_a, slope_a, out_b, slope_b;
   logic               busy_a, seg_a, busy_b, seg_b;

   int vectors     = 0;
   int miscompares = 0;

   // Model state per instance: [0] ramp of 4 cycles, [1] immediate step.
   int m_n[2]    = '{4, 1};
   int m_tgt[2];
   int m_out[2];
   int m_from[2];
   int m_s[2];
   int m_k[2];
   bit m_seg[2];

   real_to_pwl #(.WIDTH(16), .TR_LOG2(2)) dut_a (
      .clk(clk), .rst(rst), .in_val(in_val),
      .out_val(out_a), .out_slope(slope_a), .busy(busy_a), .seg_start(seg_a));

   real_to_pwl #(.WIDTH(16), .TR_LOG2(0)) dut_b (
      .clk(clk), .rst(rst), .in_val(in_val),
      .out_val(out_b), .out_slope(slope_b), .busy(busy_b), .seg_start(seg_b));

   always #5 clk = ~clk;

   // Ramp model: step k of a segment sits at from + k*s, and the last step lands on the target.
   task automatic model_edge(input int i, input bit r, input int v);
      if (r) begin
         m_tgt[i] = 0; m_out[i] = 0; m_from[i] = 0; m_s[i] = 0; m_k[i] = 0; m_seg[i] = 1'b0;
      end else begin
         if (v != m_tgt[i]) begin
            m_from[i] = m_out[i];
            m_s[i]    = (v - m_out[i]) / m_n[i];
            m_tgt[i]  = v;
            m_k[i]    = 1;
            m_seg[i]  = 1'b1;
         end else begin
            m_seg[i] = 1'b0;
            if (m_k[i] > 0 && m_k[i] < m_n[i]) m_k[i]++;
         end
         if (m_k[i] >= m_n[i]) m_out[i] = m_tgt[i];
         else if (m_k[i] > 0)  m_out[i] = m_from[i] + m_k[i] * m_s[i];
      end
   endtask

   function automatic bit m_busy(input int i);
      return (m_k[i] > 0) && (m_k[i] < m_n[i]);
   endfunction

   function automatic int m_slope(input int i);
      return m_busy(i) ? m_s[i] : 0;
   endfunction

   task automatic tick(input bit r, input logic signed [15:0] v);
      rst    = r;
      in_val = v;
      @(posedge clk);
      for (int i = 0; i < 2; i++) model_edge(i, r, int'(v));
      #1;
   endtask

   task automatic settle(input logic signed [15:0] v);
      for (int i = 0; i < 6; i++) tick(1'b0, v);
   endtask

   task automatic test_reset();
      int exp_o[4] = '{25, 50, 75, 100};
      tick(1'b1, 16'sd100);
      tick(1'b1, 16'sd100);
      vectors++;
      if ({out_a, slope_a, busy_a, seg_a} !== {16'sd0, 16'sd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_a: out=%0d slope=%0d busy=%b seg=%b, required all 0", out_a, slope_a, busy_a, seg_a);
      end
      vectors++;
      if ({out_b, slope_b, busy_b, seg_b} !== {16'sd0, 16'sd0, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL reset_b: out=%0d slope=%0d busy=%b seg=%b, required all 0", out_b, slope_b, busy_b, seg_b);
      end
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 16'sd100);
         vectors++;
         if (out_a !== 16'(exp_o[i])) begin
            miscompares++;
            $display("FAIL reset_release_ramp[%0d]: out=%0d required %0d", i, out_a, exp_o[i]);
         end
      end
   endtask

   task automatic test_step_up();
      int      exp_o[4] = '{25, 50, 75, 100};
      int      exp_s[4] = '{25, 25, 25, 0};
      bit[3:0] exp_b    = 4'b0111;
      bit[3:0] exp_g    = 4'b0001;
      settle(16'sd0);
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 16'sd100);
         vectors++;
         if ({out_a, slope_a, busy_a, seg_a} !== {16'(exp_o[i]), 16'(exp_s[i]), exp_b[i], exp_g[i]}) begin
            miscompares++;
            $display("FAIL step_up[%0d]: out=%0d slope=%0d busy=%b seg=%b, required %0d %0d %b %b",
                     i, out_a, slope_a, busy_a, seg_a, exp_o[i], exp_s[i], exp_b[i], exp_g[i]);
         end
      end
   endtask

   task automatic test_neg_step();
      int exp_o[4] = '{-2, -4, -6, -10};
      int exp_s[4] = '{-2, -2, -2, 0};
      settle(16'sd0);
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, -16'sd10);
         vectors++;
         if ({out_a, slope_a} !== {16'(exp_o[i]), 16'(exp_s[i])}) begin
            miscompares++;
            $display("FAIL neg_step[%0d]: out=%0d slope=%0d, required %0d %0d",
                     i, out_a, slope_a, exp_o[i], exp_s[i]);
         end
      end
   endtask

   task automatic test_retarget();
      int exp_o[4] = '{40, 30, 20, 10};
      settle(16'sd0);
      tick(1'b0, 16'sd100);
      tick(1'b0, 16'sd100);
      vectors++;
      if (out_a !== 16'sd50) begin
         miscompares++;
         $display("FAIL retarget_mid: out=%0d required 50", out_a);
      end
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 16'sd10);
         vectors++;
         if (out_a !== 16'(exp_o[i]) || (i < 3 && slope_a !== -16'sd10) || seg_a !== (i == 0)) begin
            miscompares++;
            $display("FAIL retarget[%0d]: out=%0d slope=%0d seg=%b, required %0d -10 %b",
                     i, out_a, slope_a, seg_a, exp_o[i], (i == 0));
         end
      end
   endtask

   task automatic test_full_scale();
      int exp_o[4] = '{-16385, -2, 16381, 32767};
      settle(-16'sd32768);
      for (int i = 0; i < 4; i++) begin
         tick(1'b0, 16'sd32767);
         vectors++;
         if (out_a !== 16'(exp_o[i]) || (i < 3 && slope_a !== 16'sd16383)) begin
            miscompares++;
            $display("FAIL full_scale[%0d]: out=%0d slope=%0d, required %0d 16383",
                     i, out_a, slope_a, exp_o[i]);
         end
      end
   endtask

   task automatic test_tr0_step();
      settle(16'sd0);
      tick(1'b0, 16'sd77);
      vectors++;
      if ({out_b, slope_b, busy_b, seg_b} !== {16'sd77, 16'sd0, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL tr0_step: out=%0d slope=%0d busy=%b seg=%b, required 77 0 0 1", out_b, slope_b, busy_b, seg_b);
      end
      tick(1'b0, 16'sd77);
      vectors++;
      if ({out_b, busy_b, seg_b} !== {16'sd77, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL tr0_hold: out=%0d busy=%b seg=%b, required 77 0 0", out_b, busy_b, seg_b);
      end
   endtask

   task automatic test_random();
      logic signed [15:0] v = in_val;
      bit                 r;
      for (int n = 0; n < 400; n++) begin
         r = ($urandom_range(0, 59) == 0);
         case ($urandom_range(0, 9))
            0, 1, 2, 3: ;
            4:       v = -16'sd32768;
            5:       v = 16'sd32767;
            6:       v = 16'($urandom_range(0, 20)) - 16'sd10;
            default: v = 16'($urandom);
         endcase
         tick(r, v);
         vectors++;
         if ({out_a, slope_a, busy_a, seg_a} !== {16'(m_out[0]), 16'(m_slope(0)), m_busy(0), m_seg[0]}) begin
            miscompares++;
            $display("FAIL random_a[%0d]: out=%0d slope=%0d busy=%b seg=%b, required %0d %0d %b %b",
                     n, out_a, slope_a, busy_a, seg_a, m_out[0], m_slope(0), m_busy(0), m_seg[0]);
         end
         vectors++;
         if ({out_b, slope_b, busy_b, seg_b} !== {16'(m_out[1]), 16'(m_slope(1)), m_busy(1), m_seg[1]}) begin
            miscompares++;
            $display("FAIL random_b[%0d]: out=%0d slope=%0d busy=%b seg=%b, required %0d %0d %b %b",
                     n, out_b, slope_b, busy_b, seg_b, m_out[1], m_slope(1), m_busy(1), m_seg[1]);
         end
      end
   endtask

   initial begin
      rst    = 1'b1;
      in_val = '0;
      for (int i = 0; i < 2; i++) model_edge(i, 1'b1, 0);
      test_reset();
      test_step_up();
      test_neg_step();
      test_retarget();
      test_full_scale();
      test_tr0_step();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
